axis_pkt_monitor: RTL and testbench
===================================

Name: axis_pkt_monitor

Overview:
- Downstream sink and checker for the 64-bit packet stream produced by the pcap replay source (data/strb/valid/sop/eop/ready).
- Accepts beats, checks framing and strobe rules, and keeps saturating statistics: packets, bytes, errors, last/min/max length, inter-packet gap.
- Synthesizable; used as the test-bench scoreboard front end and as the consumer stage of the replay path.

Parameters:
- AXIS_WIDTH, 64, data width in bits; multiple of 8. Strobe width is AXIS_WIDTH/8.
- CNT_WIDTH, 32, width of every statistics counter.
- MAX_PKT_BYTES, 9600, largest legal packet length in bytes.
- BP_SEED, 16'hACE1, LFSR seed; used only with the optional feature.

Ports:
- clk  in  1  single clock; all logic is posedge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous; zeroes all statistics without touching FSM or stream state.
- data  in  AXIS_WIDTH  beat payload; not checked.
- strb  in  AXIS_WIDTH/8  byte enables; bit k qualifies data[8k+:8].
- valid  in  1  beat valid.
- sop  in  1  first beat of packet.
- eop  in  1  last beat of packet.
- ready  out  1  sink ready.
- pkt_count  out  CNT_WIDTH  good packets completed.
- byte_count  out  CNT_WIDTH  bytes in good packets.
- err_count  out  CNT_WIDTH  error events.
- last_len  out  16  length of last good packet.
- min_len / max_len  out  16 each  extremes over good packets.
- gap_cycles  out  CNT_WIDTH  cycles from last eop acceptance to the following sop acceptance.
- in_pkt  out  1  FSM in IN_PKT.
- err_pulse  out  1  one-cycle error strobe.
- err_code  out  3  code of the most recent error.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - ready=0; all counters, last_len, max_len, gap_cycles, err_pulse and err_code = 0.
  - min_len = 16'hFFFF; FSM = IDLE.
  - ready goes to 1 on the first clk edge after rst_n deasserts.
- A beat is accepted only when valid && ready. Non-accepted cycles change only the gap counter.
- beat_len = popcount(strb). A running length accumulator (16-bit, saturating) holds the current packet length.
- IDLE state:
  - Accepted beat with sop: length = beat_len; go to IN_PKT.
  - If eop is also set, the packet completes this same beat and the FSM stays IDLE.
  - Accepted beat without sop: error NO_SOP (1); beat discarded; stay IDLE.
- IN_PKT state:
  - Accepted beat with sop: error SOP_IN_PKT (2). Current packet is dropped (no stats). The new packet restarts from this beat.
  - Accepted beat without eop and strb != all-ones: error PARTIAL_MID (3); the packet continues.
  - Accepted beat with eop: completes the packet; go to IDLE.
- Eop-beat checks, in priority order; only one error is recorded per beat:
  - strb == 0, or strb not a thermometer code starting at bit 0: STRB (4).
  - Final length > MAX_PKT_BYTES: OVERSIZE (5).
  - A packet with an error at eop is not counted as good.
  - PARTIAL_MID on an earlier beat does not disqualify the packet.
- Good completion takes effect on the next clk edge, a 1-cycle latency from eop acceptance:
  - pkt_count +1, byte_count += length, last_len = length, min/max updated.
- Any error: err_count +1 and err_pulse=1 for exactly one cycle; err_code holds until the next error or reset.
- Gap counter:
  - Starts counting at 0 in the cycle after eop acceptance and increments every clk.
  - Latched to gap_cycles on the next sop acceptance.
  - Not latched for the first packet after reset or clear.
- All counters saturate at all-ones; they never wrap.
- clear coincident with a completion: clear wins; that completion is lost.
- Reset mid-packet: the packet is abandoned; no error is counted.

Optional Feature:
- Macro: AXIS_PKT_MONITOR_BACKPRESSURE_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded with BP_SEED at reset, advances every cycle. ready = 0 whenever lfsr[1:0]==2'b00 (about 25% stall), else 1.
- Undefined: no LFSR logic; ready = 1 constantly after reset.

Decomposition:
- Shared package axis_mon_pkg holds:
  - err_code enum: NONE=0, NO_SOP=1, SOP_IN_PKT=2, PARTIAL_MID=3, STRB=4, OVERSIZE=5.
  - FSM state typedef: IDLE, IN_PKT.
  - Saturating-increment function.
- One sub-module: axis_strb_decode.
  - Combinational: outputs popcount(strb) and a thermometer-valid flag.
  - Parameterised by AXIS_WIDTH.

Test Plan:
- 60-byte packet: beats of strb FF×7, then 0F with eop -> pkt_count=1, byte_count=60, last_len=min_len=max_len=60, err_count=0.
- Single beat, sop=eop=1, strb=8'h01 -> pkt_count=1, last_len=1; FSM stays IDLE.
- Beat without sop in IDLE -> err_code=1, err_pulse for 1 cycle, err_count=1, pkt_count=0.
- sop mid-packet, then 16-byte packet -> err_code=2, pkt_count=1, last_len=16.
- eop strb=8'h05 -> err_code=4, packet not counted; 9601-byte packet -> err_code=5.
- Back-to-back packets, eop then sop 7 cycles later -> gap_cycles=6; with backpressure defined, lengths still correct with ready toggling.

Source files
------------

// File: rtl/axis_mon_pkg.sv
// Shared types and helpers for the packet monitor: error codes, FSM states, saturating add.
package axis_mon_pkg;

    typedef enum logic [2:0] {
        ERR_NONE        = 3'd0,
        ERR_NO_SOP      = 3'd1,
        ERR_SOP_IN_PKT  = 3'd2,
        ERR_PARTIAL_MID = 3'd3,
        ERR_STRB        = 3'd4,
        ERR_OVERSIZE    = 3'd5
    } err_code_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } state_t;

    // Adds b to a, clamping at the all-ones value of a w-bit counter.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b, input int w);
        logic [63:0] max_v;
        logic [64:0] sum;
        max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        sum   = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_v}) ? max_v : sum[63:0];
    endfunction

endpackage

// File: rtl/axis_strb_decode.sv
// Strobe decoder: byte count of a beat and whether strb is a nonzero thermometer code from bit 0.
// Latency: combinational.
// Backpressure: none; pure function of strb.
module axis_strb_decode #(
    parameter int AXIS_WIDTH = 64,
    localparam int SW = AXIS_WIDTH / 8,
    localparam int CW = $clog2(SW + 1)
) (
    input  logic [SW-1:0] strb,
    output logic [CW-1:0] pop,
    output logic          therm
);

    always_comb begin
        pop = '0;
        for (int k = 0; k < SW; k++) begin
            pop = pop + CW'(strb[k]);
        end
    end

    // A low-aligned run of ones has no bit set in common with itself plus one.
    assign therm = (strb != '0) && ((strb & (strb + SW'(1))) == '0);

endmodule

// File: rtl/axis_pkt_monitor.sv
// Stream sink/checker: framing and strobe checks plus saturating stats; AXIS_PKT_MONITOR_BACKPRESSURE_EN adds LFSR stalls.
// Latency: stats update one cycle after eop acceptance; err_pulse one cycle after the offending beat.
// Backpressure: ready=1 after reset, or deasserted when lfsr[1:0]==0 with the macro defined.
module axis_pkt_monitor
    import axis_mon_pkg::*;
#(
    parameter int          AXIS_WIDTH    = 64,
    parameter int          CNT_WIDTH     = 32,
    parameter int          MAX_PKT_BYTES = 9600,
    parameter logic [15:0] BP_SEED       = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic [AXIS_WIDTH-1:0]   data,
    input  logic [AXIS_WIDTH/8-1:0] strb,
    input  logic                    valid,
    input  logic                    sop,
    input  logic                    eop,
    output logic                    ready,
    output logic [CNT_WIDTH-1:0]    pkt_count,
    output logic [CNT_WIDTH-1:0]    byte_count,
    output logic [CNT_WIDTH-1:0]    err_count,
    output logic [15:0]             last_len,
    output logic [15:0]             min_len,
    output logic [15:0]             max_len,
    output logic [CNT_WIDTH-1:0]    gap_cycles,
    output logic                    in_pkt,
    output logic                    err_pulse,
    output logic [2:0]              err_code
);

    localparam int SW = AXIS_WIDTH / 8;
    localparam int CW = $clog2(SW + 1);

    state_t               state_q, state_d;
    logic [15:0]          len_q, len_d, len_sum, fin_len, done_len;
    logic [CW-1:0]        beat_pop;
    logic                 strb_therm, acc, ready_q, done_vld;
    logic                 err_vld, good_eop, gap_armed;
    err_code_t            err_d, err_code_q;
    logic [CNT_WIDTH-1:0] gap_run;
    logic                 unused_data;

    assign unused_data = ^data;

    axis_strb_decode #(.AXIS_WIDTH(AXIS_WIDTH)) u_strb_decode (
        .strb  (strb),
        .pop   (beat_pop),
        .therm (strb_therm)
    );

`ifdef AXIS_PKT_MONITOR_BACKPRESSURE_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= BP_SEED;
        else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign ready = ready_q & (lfsr[1:0] != 2'b00);
`else
    logic unused_bp_seed;
    assign unused_bp_seed = ^BP_SEED;
    assign ready = ready_q;
`endif

    assign acc      = valid & ready;
    assign in_pkt   = (state_q == ST_IN_PKT);
    assign err_code = err_code_q;
    assign len_sum  = 16'(sat_add(64'(len_q), 64'(beat_pop), 16));

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        fin_len  = len_q;
        err_vld  = 1'b0;
        err_d    = ERR_NONE;
        good_eop = 1'b0;
        if (acc) begin
            if (state_q == ST_IDLE && !sop) begin
                err_vld = 1'b1;
                err_d   = ERR_NO_SOP;
            end else begin
                if (sop) begin
                    fin_len = 16'(beat_pop);
                    if (state_q == ST_IN_PKT) begin
                        err_vld = 1'b1;
                        err_d   = ERR_SOP_IN_PKT;
                    end
                end else begin
                    fin_len = len_sum;
                end
                len_d   = fin_len;
                state_d = ST_IN_PKT;
                if (eop) begin
                    state_d = ST_IDLE;
                    // At most one error per beat; an earlier one on this beat keeps its code.
                    if (!strb_therm) begin
                        if (!err_vld) err_d = ERR_STRB;
                        err_vld = 1'b1;
                    end else if ({16'd0, fin_len} > 32'(MAX_PKT_BYTES)) begin
                        if (!err_vld) err_d = ERR_OVERSIZE;
                        err_vld = 1'b1;
                    end else if (!err_vld) begin
                        good_eop = 1'b1;
                    end
                end else if (!sop && strb != '1) begin
                    err_vld = 1'b1;
                    err_d   = ERR_PARTIAL_MID;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            ready_q    <= 1'b0;
            done_vld   <= 1'b0;
            done_len   <= '0;
            err_pulse  <= 1'b0;
            err_code_q <= ERR_NONE;
            pkt_count  <= '0;
            byte_count <= '0;
            err_count  <= '0;
            last_len   <= '0;
            min_len    <= 16'hFFFF;
            max_len    <= '0;
            gap_cycles <= '0;
            gap_run    <= '0;
            gap_armed  <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            ready_q   <= 1'b1;
            done_vld  <= good_eop & ~clear;
            done_len  <= fin_len;
            err_pulse <= err_vld;
            if (err_vld) err_code_q <= err_d;
            if (clear) begin
                pkt_count  <= '0;
                byte_count <= '0;
                err_count  <= '0;
                last_len   <= '0;
                min_len    <= 16'hFFFF;
                max_len    <= '0;
                gap_cycles <= '0;
                gap_run    <= '0;
                gap_armed  <= 1'b0;
            end else begin
                if (done_vld) begin
                    pkt_count  <= CNT_WIDTH'(sat_add(64'(pkt_count), 64'd1, CNT_WIDTH));
                    byte_count <= CNT_WIDTH'(sat_add(64'(byte_count), 64'(done_len), CNT_WIDTH));
                    last_len   <= done_len;
                    if (done_len < min_len) min_len <= done_len;
                    if (done_len > max_len) max_len <= done_len;
                end
                if (err_vld) err_count <= CNT_WIDTH'(sat_add(64'(err_count), 64'd1, CNT_WIDTH));
                if (acc && sop && gap_armed) begin
                    gap_cycles <= gap_run;
                    gap_armed  <= 1'b0;
                end
                // An eop arms the next latch even if the same beat also consumed the previous gap.
                if (acc && eop) begin
                    gap_run   <= '0;
                    gap_armed <= 1'b1;
                end else begin
                    gap_run <= CNT_WIDTH'(sat_add(64'(gap_run), 64'd1, CNT_WIDTH));
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_pkt_monitor.sv
// Randomized and directed bench for axis_pkt_monitor against a packet-level reference model.
module tb_axis_pkt_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic [63:0] data = '0;
    logic [7:0]  strb = '0;
    logic        valid = 1'b0, sop = 1'b0, eop = 1'b0;
    logic        ready, in_pkt, err_pulse;
    logic [31:0] pkt_count, byte_count, err_count, gap_cycles;
    logic [15:0] last_len, min_len, max_len;
    logic [2:0]  err_code;

    axis_pkt_monitor dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .data(data), .strb(strb),
        .valid(valid), .sop(sop), .eop(eop), .ready(ready),
        .pkt_count(pkt_count), .byte_count(byte_count), .err_count(err_count),
        .last_len(last_len), .min_len(min_len), .max_len(max_len),
        .gap_cycles(gap_cycles), .in_pkt(in_pkt), .err_pulse(err_pulse), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: packet-level bookkeeping straight from the framing rules.
    longint m_pkt, m_bytes, m_err, m_last, m_min, m_max, m_gap, m_gap_run;
    bit     m_gap_armed, m_in, m_pend, m_pulse;
    int     m_len, m_pend_len, m_code;

    task automatic model_reset();
        m_pkt = 0; m_bytes = 0; m_err = 0; m_last = 0; m_min = 65535; m_max = 0;
        m_gap = 0; m_gap_run = 0; m_gap_armed = 0; m_in = 0; m_pend = 0;
        m_pulse = 0; m_len = 0; m_pend_len = 0; m_code = 0;
    endtask

    task automatic model_edge(input bit acc, input bit s, input bit e, input logic [7:0] st, input bit clr);
        bit err, good, therm;
        int code, bl;
        err = 0; good = 0; code = 0;
        if (acc) begin
            bl = $countones(st);
            if (!m_in && !s) begin
                err = 1; code = 1;
            end else begin
                if (s) begin
                    if (m_in) begin err = 1; code = 2; end
                    m_len = bl;
                end else begin
                    m_len = (m_len + bl > 65535) ? 65535 : m_len + bl;
                end
                m_in = 1;
                if (e) begin
                    m_in = 0;
                    therm = (st != 0) && (int'(st) == (1 << bl) - 1);
                    if (!therm) begin
                        if (!err) code = 4;
                        err = 1;
                    end else if (m_len > 9600) begin
                        if (!err) code = 5;
                        err = 1;
                    end else if (!err) begin
                        good = 1;
                    end
                end else if (!s && st != 8'hFF) begin
                    err = 1; code = 3;
                end
            end
        end
        if (clr) begin
            m_pkt = 0; m_bytes = 0; m_err = 0; m_last = 0; m_min = 65535; m_max = 0;
            m_gap = 0; m_gap_run = 0; m_gap_armed = 0; m_pend = 0;
        end else begin
            if (m_pend) begin
                m_pkt++;
                m_bytes += m_pend_len;
                m_last = m_pend_len;
                if (m_pend_len < m_min) m_min = m_pend_len;
                if (m_pend_len > m_max) m_max = m_pend_len;
            end
            if (err) m_err++;
            if (acc && s && m_gap_armed) begin m_gap = m_gap_run; m_gap_armed = 0; end
            if (acc && e) begin m_gap_run = 0; m_gap_armed = 1; end
            else m_gap_run++;
            m_pend = good;
            m_pend_len = m_len;
        end
        m_pulse = err;
        if (err) m_code = code;
    endtask

    task automatic check_all();
        chk("pkt_count", pkt_count, m_pkt);
        chk("byte_count", byte_count, m_bytes);
        chk("err_count", err_count, m_err);
        chk("last_len", last_len, m_last);
        chk("min_len", min_len, m_min);
        chk("max_len", max_len, m_max);
        chk("gap_cycles", gap_cycles, m_gap);
        chk("in_pkt", in_pkt, m_in);
        chk("err_pulse", err_pulse, m_pulse);
        chk("err_code", err_code, m_code);
`ifndef AXIS_PKT_MONITOR_BACKPRESSURE_EN
        chk("ready", ready, 1);
`endif
    endtask

    // One clock: drive at the falling edge, let the model see the rising edge, check at the next falling edge.
    task automatic cycle(input bit v, input bit s, input bit e, input logic [7:0] st, input bit clr, output bit acc);
        bit rdy;
        valid = v; sop = s; eop = e; strb = st; clear = clr;
        data = {$urandom, $urandom};
        rdy = ready;
        @(posedge clk);
        acc = v && rdy;
        model_edge(acc, s, e, st, clr);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 8'h00, 0, acc);
    endtask

    task automatic do_clear();
        bit acc;
        cycle(0, 0, 0, 8'h00, 1, acc);
    endtask

    task automatic beat(input bit s, input bit e, input logic [7:0] st);
        bit acc;
        int tries;
        acc = 0; tries = 0;
        while (!acc && tries < 64) begin
            cycle(1, s, e, st, 0, acc);
            tries++;
        end
        chk("beat_accepted", {63'd0, acc}, 1);
    endtask

    task automatic send_pkt(input int len);
        int rem;
        bit first;
        rem = len; first = 1;
        while (rem > 8) begin
            beat(first, 0, 8'hFF);
            first = 0;
            rem -= 8;
        end
        beat(first, 1, 8'((1 << rem) - 1));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bad_tbl [5];
        bad_tbl[0] = 8'h00; bad_tbl[1] = 8'h05; bad_tbl[2] = 8'h02;
        bad_tbl[3] = 8'h80; bad_tbl[4] = 8'hFE;
        model_reset();
        #12;
        chk("rst_ready", ready, 0);
        chk("rst_pkt", pkt_count, 0);
        chk("rst_bytes", byte_count, 0);
        chk("rst_err", err_count, 0);
        chk("rst_min", min_len, 16'hFFFF);
        chk("rst_max", max_len, 0);
        chk("rst_last", last_len, 0);
        chk("rst_gap", gap_cycles, 0);
        chk("rst_in_pkt", in_pkt, 0);
        chk("rst_err_pulse", err_pulse, 0);
        chk("rst_err_code", err_code, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", ready, 0);
        idle(2);

        // 60-byte packet
        do_clear();
        for (int i = 0; i < 7; i++) beat(i == 0, 0, 8'hFF);
        beat(0, 1, 8'h0F);
        idle(2);
        chk("t60_pkt", pkt_count, 1);
        chk("t60_bytes", byte_count, 60);
        chk("t60_last", last_len, 60);
        chk("t60_min", min_len, 60);
        chk("t60_max", max_len, 60);
        chk("t60_err", err_count, 0);

        // single-beat packet
        do_clear();
        beat(1, 1, 8'h01);
        chk("t1_in_pkt", in_pkt, 0);
        idle(2);
        chk("t1_pkt", pkt_count, 1);
        chk("t1_last", last_len, 1);

        // beat without sop while idle
        do_clear();
        beat(0, 0, 8'hFF);
        chk("nosop_pulse", err_pulse, 1);
        idle(1);
        chk("nosop_pulse_drop", err_pulse, 0);
        chk("nosop_code", err_code, 1);
        chk("nosop_err", err_count, 1);
        chk("nosop_pkt", pkt_count, 0);

        // sop inside a packet restarts it
        do_clear();
        beat(1, 0, 8'hFF); beat(0, 0, 8'hFF); beat(1, 0, 8'hFF); beat(0, 1, 8'hFF);
        idle(2);
        chk("sopin_code", err_code, 2);
        chk("sopin_pkt", pkt_count, 1);
        chk("sopin_last", last_len, 16);

        // bad eop strobe, then length just over and exactly at the limit
        do_clear();
        beat(1, 0, 8'hFF); beat(0, 1, 8'h05);
        idle(2);
        chk("strb_code", err_code, 4);
        chk("strb_pkt", pkt_count, 0);
        send_pkt(9601);
        idle(2);
        chk("over_code", err_code, 5);
        chk("over_pkt", pkt_count, 0);
        chk("over_err", err_count, 2);
        send_pkt(9600);
        idle(2);
        chk("max_ok_pkt", pkt_count, 1);
        chk("max_ok_last", last_len, 9600);

        // inter-packet gap
        do_clear();
        send_pkt(16);
        chk("gap_first", gap_cycles, 0);
        idle(6);
        send_pkt(8);
        idle(1);
`ifndef AXIS_PKT_MONITOR_BACKPRESSURE_EN
        chk("gap_six", gap_cycles, 6);
`endif

        // randomized traffic
        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 9))
                0: beat(0, 0, 8'hFF);
                1: begin
                    beat(1, 0, 8'hFF);
                    if ($urandom_range(0, 1) == 1) beat(0, 0, 8'hFF);
                    send_pkt($urandom_range(9, 100));
                end
                2: begin
                    beat(1, 0, 8'hFF);
                    beat(0, 0, 8'($urandom_range(0, 254)));
                    beat(0, 1, 8'h0F);
                end
                3: begin
                    beat(1, 0, 8'hFF);
                    beat(0, 1, bad_tbl[$urandom_range(0, 4)]);
                end
                default: send_pkt($urandom_range(1, 300));
            endcase
            idle($urandom_range(0, 4));
            if (i % 50 == 49) begin
                idle(1);
                do_clear();
            end
        end

        // reset in the middle of a packet
        beat(1, 0, 8'hFF);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_in_pkt", in_pkt, 0);
        chk("midrst_err", err_count, 0);
        chk("midrst_ready", ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        send_pkt(10);
        idle(2);
        chk("midrst_pkt", pkt_count, 1);
        chk("midrst_last", last_len, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
